systolic_skew_feeder: RTL and testbench
=======================================

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter N, default 4, array dimension (rows = columns = N); legal 1..16.
REQ-002 Parameter DATAWIDTH, default 32, IEEE-754 single-precision word width.
REQ-003 Parameter KW, default 16, width of the k_len count.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 MCLK  in  1  master clock; all state updates on posedge.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle request to begin a matrix product; sampled in IDLE only.
REQ-008 k_len  in  KW  inner dimension K; sampled on an accepted start.
REQ-009 a_valid, a_ready  in, out  1 each  A-column-vector handshake.
REQ-010 a_data  in  N*DATAWIDTH  A[0..N-1][k]; lane i occupies bits [i*DATAWIDTH +: DATAWIDTH].
REQ-011 b_valid, b_ready  in, out  1 each  B-row-vector handshake.
REQ-012 b_data  in  N*DATAWIDTH  B[k][0..N-1]; lane j is packed the same way as a_data.
REQ-013 x_edge  out  N*DATAWIDTH  left-edge x_in of array row i.
REQ-014 y_edge  out  N*DATAWIDTH  top-edge y_in of array column j.
REQ-015 pe_wen  out  1  array load/accumulate enable; 0 clears the accumulators (parent ties readin to 0).
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 FSM states: IDLE, CLEAR, STREAM, FLUSH, DONE.
REQ-019 IDLE -> CLEAR on start=1; start in any other state is ignored.
REQ-020 CLEAR lasts 1 cycle with pe_wen=0; then STREAM if k_len!=0, else DONE.
REQ-021 In STREAM: a_ready = b_ready = a_valid & b_valid; a transfer occurs only when both vectors are valid together; ready is 0 in every other state.
REQ-022 STREAM counts transfers; after the k_len-th transfer, go to FLUSH in the next cycle.
REQ-023 A STREAM cycle without a transfer injects an all-zero vector into both A and B lanes, so alignment is preserved.
REQ-024 FLUSH injects zero vectors for exactly 2N-1 cycles, then goes to DONE.
REQ-025 DONE lasts 1 cycle with done=1, then goes to IDLE.
REQ-026 Skew: lane i of x_edge equals a_data lane i from i+1 cycles earlier; lane j of y_edge equals b_data lane j from j+1 cycles earlier (register output, lane 0 latency 1).
REQ-027 x_edge and y_edge are 0 whenever pe_wen=0 and in IDLE.
REQ-028 pe_wen=1 in STREAM, FLUSH, DONE and IDLE.
REQ-029 The transfer counter is KW bits wide with no wrap; k_len = 2^KW-1 is legal.
REQ-030 The block performs no arithmetic on data; words pass bit-exact, including NaN and -0.

Reset
REQ-031 On RST=1: state=IDLE; all skew registers, x_edge and y_edge = 0; counters = 0; done=0; busy=0; a_ready=b_ready=0.
REQ-032 pe_wen is registered with reset value 0, so reset also clears the array; it returns to 1 on the first cycle after RST=0.
REQ-033 RST mid-operation aborts immediately; no done pulse is issued.

Configuration
REQ-034 With macro SYSTOLIC_FEEDER_PERF_CNT_EN defined: extra output stall_cycles[31:0] counts STREAM cycles without a transfer; it clears on an accepted start and on RST, and saturates at 2^32-1.
REQ-035 Without SYSTOLIC_FEEDER_PERF_CNT_EN: the stall_cycles port and its counter are absent; all other behaviour is identical.

Structure
REQ-036 Shared package systolic_pkg holds: DATAWIDTH, FP_ZERO (32'h0), the feeder state enum, and the lane-slice helper constants.
REQ-037 One sub-module, skew_line (parameters DEPTH and DATAWIDTH): a DEPTH-stage zero-resettable delay line; the feeder instantiates 2N of them.

Verification
REQ-038 N=4, k_len=1, A lanes = 1.0/2.0/3.0/4.0, B lanes = 1.0 -> x_edge lane 3 = 4.0 exactly 4 cycles after the transfer; done exactly 1+1+7+1 cycles after start accepted.
REQ-039 k_len=0 -> CLEAR 1 cycle, then done next cycle; a_ready is never 1.
REQ-040 a_valid=1, b_valid toggles 1,0,1 with k_len=2 -> 2 transfers; one zero bubble appears on all lanes; stall_cycles=1 when the macro is defined.
REQ-041 RST asserted in the 3rd STREAM cycle -> next cycle all outputs = 0, pe_wen=0, state IDLE, no done pulse.
REQ-042 start re-pulsed during FLUSH -> ignored; a single done pulse; k_len unchanged.
REQ-043 End-to-end with a 4x4 array, identity A, B = 1..16 (k_len=4) -> accumulators equal B after done.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array skew feeder.
//   DATAWIDTH       : default IEEE-754 single-precision word width
//   FP_ZERO         : bit pattern injected into idle lanes
//   feeder_state_e  : feeder FSM state encoding
//   lane_lsb()      : low bit index of a lane inside a packed lane vector
package systolic_pkg;

  localparam int unsigned DATAWIDTH = 32;
  localparam logic [31:0] FP_ZERO   = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StFlush,
    StDone
  } feeder_state_e;

  // Lane i of a packed vector occupies [lane_lsb(i, w) +: w].
  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// A-column / B-row vector streaming interface.
//   a_valid/a_ready/a_data : A[0..N-1][k], lane i at [i*DATAWIDTH +: DATAWIDTH]
//   b_valid/b_ready/b_data : B[k][0..N-1], lane j packed the same way
// Modports: master = vector source, slave = feeder.
interface systolic_skew_feeder_if #(
  parameter int unsigned N         = 4,
  parameter int unsigned DATAWIDTH = 32
);

  logic                   a_valid;
  logic                   a_ready;
  logic [N*DATAWIDTH-1:0] a_data;
  logic                   b_valid;
  logic                   b_ready;
  logic [N*DATAWIDTH-1:0] b_data;

  modport master (
    output a_valid,
    output a_data,
    output b_valid,
    output b_data,
    input  a_ready,
    input  b_ready
  );

  modport slave (
    input  a_valid,
    input  a_data,
    input  b_valid,
    input  b_data,
    output a_ready,
    output b_ready
  );

endinterface

// File: rtl/skew_line.sv
// DEPTH-stage delay line with synchronous zero reset.
//   clk  : clock, rst : synchronous active-high clear of every stage
//   din  : word entering stage 0
//   dout : word leaving the last stage (DEPTH cycles after din)
module skew_line #(
  parameter int unsigned DEPTH     = 1,
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] din,
  output logic [DATAWIDTH-1:0] dout
);

  logic [DATAWIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int s = 1; s < DEPTH; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skewed edge feeder for an N x N output-stationary systolic array.
// Accepts K A-column / B-row vector pairs, skews lane i by i+1 cycles onto the
// array's left (x_edge) and top (y_edge) edges, then flushes 2N-1 zero cycles.
//   MCLK, RST    : clock, synchronous active-high reset
//   start, k_len : begin a product of inner dimension k_len (sampled in IDLE)
//   vec          : A/B vector handshake (slave modport)
//   x_edge       : row i x_in, y_edge : column j y_in
//   pe_wen       : registered array enable, 0 clears the accumulators
//   busy, done   : not-idle flag, one-cycle completion pulse
// Optional: define SYSTOLIC_FEEDER_PERF_CNT_EN to add stall_cycles, a
// saturating count of STREAM cycles without a transfer.
module systolic_skew_feeder #(
  parameter int unsigned N         = 4,
  parameter int unsigned DATAWIDTH = systolic_pkg::DATAWIDTH,
  parameter int unsigned KW        = 16
) (
  input  logic                   MCLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  systolic_skew_feeder_if.slave  vec,
  output logic [N*DATAWIDTH-1:0] x_edge,
  output logic [N*DATAWIDTH-1:0] y_edge,
  output logic                   pe_wen,
  output logic                   busy,
  output logic                   done
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  import systolic_pkg::*;

  localparam int unsigned FlushLen = 2 * N - 1;
  localparam int unsigned FW       = $clog2(2 * N);
  localparam logic [DATAWIDTH-1:0] LaneZero = DATAWIDTH'(FP_ZERO);

  feeder_state_e state_q, state_d;

  logic [KW-1:0] k_len_q;
  logic [KW-1:0] xfer_cnt_q;
  logic [FW-1:0] flush_cnt_q;
  logic          pe_wen_q;

  logic in_stream;
  logic xfer;
  logic start_acc;
  logic last_xfer;
  logic flush_last;

  assign start_acc  = (state_q == StIdle) && start;
  // xfer_cnt_q < k_len_q while streaming, so neither side can wrap.
  assign last_xfer  = (xfer_cnt_q == k_len_q - KW'(1));
  assign flush_last = (flush_cnt_q == FW'(FlushLen - 1));

  // FSM: state register
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StClear;
      StClear:  state_d = (k_len_q != '0) ? StStream : StDone;
      StStream: if (xfer && last_xfer) state_d = StFlush;
      StFlush:  if (flush_last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = 1'b1;
    done      = 1'b0;
    in_stream = 1'b0;
    unique case (state_q)
      StIdle:   busy = 1'b0;
      StStream: in_stream = 1'b1;
      StDone:   done = 1'b1;
      default:  ;
    endcase
    // Both vectors must be present together; ready mirrors that condition.
    xfer        = in_stream & vec.a_valid & vec.b_valid;
    vec.a_ready = xfer;
    vec.b_ready = xfer;
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      k_len_q     <= '0;
      xfer_cnt_q  <= '0;
      flush_cnt_q <= '0;
      pe_wen_q    <= 1'b0;
    end else begin
      if (start_acc) begin
        k_len_q    <= k_len;
        xfer_cnt_q <= '0;
      end else if (xfer) begin
        xfer_cnt_q <= xfer_cnt_q + KW'(1);
      end
      if (state_q == StFlush) begin
        flush_cnt_q <= flush_cnt_q + FW'(1);
      end else begin
        flush_cnt_q <= '0;
      end
      // Registered so the array sees exactly one clear cycle, aligned with CLEAR.
      pe_wen_q <= (state_d != StClear);
    end
  end

  assign pe_wen = pe_wen_q;

  // Non-transfer cycles inject zeros so every lane keeps its K alignment, and
  // FLUSH drains at least N zeros, leaving the lines empty on return to IDLE.
  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int unsigned Lsb = lane_lsb(i, DATAWIDTH);

    logic [DATAWIDTH-1:0] a_inj;
    logic [DATAWIDTH-1:0] b_inj;

    assign a_inj = xfer ? vec.a_data[Lsb +: DATAWIDTH] : LaneZero;
    assign b_inj = xfer ? vec.b_data[Lsb +: DATAWIDTH] : LaneZero;

    skew_line #(
      .DEPTH    (i + 1),
      .DATAWIDTH(DATAWIDTH)
    ) u_skew_a (
      .clk (MCLK),
      .rst (RST),
      .din (a_inj),
      .dout(x_edge[Lsb +: DATAWIDTH])
    );

    skew_line #(
      .DEPTH    (i + 1),
      .DATAWIDTH(DATAWIDTH)
    ) u_skew_b (
      .clk (MCLK),
      .rst (RST),
      .din (b_inj),
      .dout(y_edge[Lsb +: DATAWIDTH])
    );
  end

`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge MCLK) begin
    if (RST || start_acc) begin
      stall_q <= '0;
    end else if (in_stream && !xfer && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 32;

  localparam logic [31:0] F1   = 32'h3F80_0000;
  localparam logic [31:0] F2   = 32'h4000_0000;
  localparam logic [31:0] F3   = 32'h4040_0000;
  localparam logic [31:0] F4   = 32'h4080_0000;
  localparam logic [31:0] NAN  = 32'h7FC0_0001;
  localparam logic [31:0] NEG0 = 32'h8000_0000;
  localparam logic [31:0] NINF = 32'hFF80_0000;
  // Hand-written single-precision encodings of 0..16.
  localparam logic [31:0] FpOf [17] = '{
    32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
    32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000,
    32'h4120_0000, 32'h4130_0000, 32'h4140_0000, 32'h4150_0000, 32'h4160_0000,
    32'h4170_0000, 32'h4180_0000
  };

  logic               MCLK = 1'b0;
  logic               RST;
  logic               start;
  logic [15:0]        k_len;
  logic [N*DW-1:0]    x_edge;
  logic [N*DW-1:0]    y_edge;
  logic               pe_wen;
  logic               busy;
  logic               done;
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
  logic [31:0]        stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  systolic_skew_feeder_if #(.N(N), .DATAWIDTH(DW)) vec_if ();

  systolic_skew_feeder #(
    .N        (N),
    .DATAWIDTH(DW),
    .KW       (16)
  ) dut (
    .MCLK  (MCLK),
    .RST   (RST),
    .start (start),
    .k_len (k_len),
    .vec   (vec_if),
    .x_edge(x_edge),
    .y_edge(y_edge),
    .pe_wen(pe_wen),
    .busy  (busy),
    .done  (done)
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 MCLK = ~MCLK;

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [31:0] lane(input logic [127:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  // Small non-negative integer decode; anything else maps to a poison value.
  function automatic int fp2int(input logic [31:0] f);
    int         e;
    logic [23:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    if (e < 0 || e > 23) return -100000;
    return int'(m >> (23 - e));
  endfunction

  // Downstream 4x4 output-stationary array model.
  int          acc  [N][N];
  logic [31:0] xr   [N][N];
  logic [31:0] yr   [N][N];
  int          nacc [N][N];
  logic [31:0] nxr  [N][N];
  logic [31:0] nyr  [N][N];

  always @(negedge MCLK) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [31:0] xin;
        logic [31:0] yin;
        if (j == 0) xin = lane(x_edge, i);
        else        xin = xr[i][j-1];
        if (i == 0) yin = lane(y_edge, j);
        else        yin = yr[i-1][j];
        if (!pe_wen) begin
          nacc[i][j] = 0;
          nxr[i][j]  = '0;
          nyr[i][j]  = '0;
        end else begin
          nacc[i][j] = acc[i][j] + fp2int(xin) * fp2int(yin);
          nxr[i][j]  = xin;
          nyr[i][j]  = yin;
        end
      end
    end
    acc = nacc;
    xr  = nxr;
    yr  = nyr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first;
    int waited;

    // Reset
    RST = 1'b1; start = 1'b0; k_len = '0;
    vec_if.a_valid = 1'b1; vec_if.b_valid = 1'b1;
    vec_if.a_data  = pack4(F1, F2, F3, F4);
    vec_if.b_data  = pack4(F1, F1, F1, F1);
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pe_wen", pe_wen, 1'b0);
    check("rst_x_edge", x_edge, '0);
    check("rst_y_edge", y_edge, '0);
    check("rst_a_ready", vec_if.a_ready, 1'b0);
    RST = 1'b0;
    tick();
    check("rel_pe_wen", pe_wen, 1'b1);
    check("rel_busy", busy, 1'b0);

    // k_len=1, single transfer, latency and done timing
    k_len = 16'd1; start = 1'b1;
    tick(); start = 1'b0;                       // C1 CLEAR
    check("t1_clear_pe_wen", pe_wen, 1'b0);
    check("t1_clear_busy", busy, 1'b1);
    check("t1_clear_ready", vec_if.a_ready, 1'b0);
    tick();                                     // C2 STREAM
    check("t1_stream_a_ready", vec_if.a_ready, 1'b1);
    check("t1_stream_b_ready", vec_if.b_ready, 1'b1);
    tick();                                     // C3
    vec_if.a_valid = 1'b0; vec_if.b_valid = 1'b0;
    vec_if.a_data = '1; vec_if.b_data = '1;
    check("t1_x_c3", x_edge, pack4(F1, 32'h0, 32'h0, 32'h0));
    check("t1_y_c3", y_edge, pack4(F1, 32'h0, 32'h0, 32'h0));
    tick(); tick();                             // C5
    check("t1_x3_c5", lane(x_edge, 3), 32'h0);
    tick();                                     // C6
    check("t1_x_c6", x_edge, pack4(32'h0, 32'h0, 32'h0, F4));
    check("t1_y_c6", y_edge, pack4(32'h0, 32'h0, 32'h0, F1));
    tick(); tick(); tick();                     // C9
    check("t1_done_c9", done, 1'b0);
    tick();                                     // C10
    check("t1_done_c10", done, 1'b1);
    check("t1_busy_c10", busy, 1'b1);
    tick();
    check("t1_done_c11", done, 1'b0);
    check("t1_idle_busy", busy, 1'b0);

    // k_len=0
    k_len = 16'd0; vec_if.a_valid = 1'b1; vec_if.b_valid = 1'b1; start = 1'b1;
    tick(); start = 1'b0;                       // C1 CLEAR
    check("t2_clear_pe_wen", pe_wen, 1'b0);
    check("t2_clear_ready", vec_if.a_ready, 1'b0);
    tick();                                     // C2 DONE
    check("t2_done", done, 1'b1);
    check("t2_done_ready", vec_if.a_ready, 1'b0);
    tick();
    check("t2_after_done", done, 1'b0);
    check("t2_after_busy", busy, 1'b0);

    // k_len=2 with a bubble; bit-exact NaN, -0, -inf
    k_len = 16'd2;
    vec_if.a_data = pack4(NAN, NEG0, F3, F4);
    vec_if.b_data = pack4(F2, F2, F2, NINF);
    start = 1'b1;
    tick(); start = 1'b0;                       // C1
    tick();                                     // C2 STREAM
    check("t3_ready_1", vec_if.a_ready, 1'b1);
    tick();                                     // C3
    vec_if.b_valid = 1'b0;
    vec_if.a_data = pack4(FpOf[5], FpOf[6], FpOf[7], FpOf[8]);
    #1;
    check("t3_bubble_a_ready", vec_if.a_ready, 1'b0);
    check("t3_bubble_b_ready", vec_if.b_ready, 1'b0);
    check("t3_x_c3_nan", x_edge, pack4(NAN, 32'h0, 32'h0, 32'h0));
    tick();                                     // C4
    vec_if.b_valid = 1'b1;
    vec_if.b_data = pack4(FpOf[9], FpOf[10], FpOf[11], FpOf[12]);
    check("t3_x_c4_neg0", x_edge, pack4(32'h0, NEG0, 32'h0, 32'h0));
    tick();                                     // C5
    check("t3_x0_c5", lane(x_edge, 0), FpOf[5]);
    check("t3_y0_c5", lane(y_edge, 0), FpOf[9]);
    check("t3_flush_ready", vec_if.a_ready, 1'b0);
    vec_if.a_valid = 1'b0; vec_if.b_valid = 1'b0;
    tick();                                     // C6
    check("t3_x_c6", x_edge, pack4(32'h0, FpOf[6], 32'h0, F4));
    check("t3_y_c6", y_edge, pack4(32'h0, FpOf[10], 32'h0, NINF));
    tick();                                     // C7
    check("t3_x_c7", x_edge, pack4(32'h0, 32'h0, FpOf[7], 32'h0));
    tick();                                     // C8
    check("t3_x_c8", x_edge, pack4(32'h0, 32'h0, 32'h0, FpOf[8]));
    waited = 0;
    while (!done && waited < 20) begin
      tick();
      waited++;
    end
    check("t3_done_delay", 32'(waited), 32'd4);
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
    check("t3_stall_cycles", stall_cycles, 32'd1);
`endif
    tick();

    // Reset in the third STREAM cycle
    k_len = 16'd5; vec_if.a_valid = 1'b1; vec_if.b_valid = 1'b1;
    vec_if.a_data = pack4(F1, F2, F3, F4);
    vec_if.b_data = pack4(F4, F3, F2, F1);
    start = 1'b1;
    tick(); start = 1'b0;                       // C1
    tick(); tick(); tick();                     // C4, 3rd STREAM cycle
    check("t4_pre_rst_x0", lane(x_edge, 0), F1);
    RST = 1'b1;
    tick();
    check("t4_rst_x_edge", x_edge, '0);
    check("t4_rst_y_edge", y_edge, '0);
    check("t4_rst_pe_wen", pe_wen, 1'b0);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_ready", vec_if.a_ready, 1'b0);
    RST = 1'b0;
    pulses = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (done) pulses++;
    end
    check("t4_no_done", 32'(pulses), 32'd0);
    check("t4_idle", busy, 1'b0);

    // start re-pulsed during FLUSH
    k_len = 16'd1;
    start = 1'b1;
    tick(); start = 1'b0;                       // C1
    tick();                                     // C2
    tick();                                     // C3 FLUSH
    vec_if.a_valid = 1'b0; vec_if.b_valid = 1'b0;
    tick();                                     // C4
    k_len = 16'd7; start = 1'b1;
    tick(); start = 1'b0;                       // C5
    check("t5_busy", busy, 1'b1);
    check("t5_pe_wen", pe_wen, 1'b1);
    pulses = 0; first = -1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (done) begin
        pulses++;
        if (first < 0) first = t;
      end
    end
    check("t5_done_pulses", 32'(pulses), 32'd1);
    check("t5_done_pos", 32'(first), 32'd5);
    check("t5_idle", busy, 1'b0);

    // End to end: identity A times B = 1..16
    k_len = 16'd4; start = 1'b1;
    tick(); start = 1'b0;                       // C1
    tick();                                     // C2
    vec_if.a_valid = 1'b1; vec_if.b_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vec_if.a_data = pack4(k == 0 ? F1 : 32'h0, k == 1 ? F1 : 32'h0,
                            k == 2 ? F1 : 32'h0, k == 3 ? F1 : 32'h0);
      vec_if.b_data = pack4(FpOf[4*k+1], FpOf[4*k+2], FpOf[4*k+3], FpOf[4*k+4]);
      tick();
    end
    vec_if.a_valid = 1'b0; vec_if.b_valid = 1'b0;
    waited = 0;
    while (!done && waited < 30) begin
      tick();
      waited++;
    end
    check("t6_done_delay", 32'(waited), 32'd7);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        check($sformatf("t6_acc_%0d_%0d", i, j), 32'(acc[i][j]), 32'(4 * i + j + 1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
